// File: rtl/dcache_sa_if.sv
// dcache_sa_if: MEM-stage data port, word-serial memory port and statistics of dcache_sa.
interface dcache_sa_if;
    logic [31:0] addr;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        miss;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    modport slave (
        input  addr, rd_req, wr_req, wr_data, mem_rdata, mem_ack,
        output rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );
    modport master (
        output addr, rd_req, wr_req, wr_data, mem_rdata, mem_ack,
        input  rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
    );
endinterface

// File: rtl/dcache_sa.sv
// dcache_sa: set-associative write-back write-allocate data cache with LRU/FIFO replacement.
module dcache_sa #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 2,
    parameter int TAG_ADDR_LEN  = 10,
    parameter int WAY_CNT       = 2,
    parameter int REPLACE       = 1
) (
    input logic        clk,
    input logic        rst,
    dcache_sa_if.slave bus
);
    localparam int N    = 1 << LINE_ADDR_LEN;
    localparam int SETS = 1 << SET_ADDR_LEN;
    localparam int WAYW = WAY_CNT > 1 ? $clog2(WAY_CNT) : 1;

    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} stateT;

    logic [31:0]             dataMem  [WAY_CNT][SETS][N];
    logic [TAG_ADDR_LEN-1:0] tagMem   [WAY_CNT][SETS];
    logic                    validBits[WAY_CNT][SETS];
    logic                    dirtyBits[WAY_CNT][SETS];
    logic [WAYW-1:0]         ages     [WAY_CNT][SETS];
    logic [WAYW-1:0]         fifoPtr  [SETS];

    stateT                    state;
    logic [LINE_ADDR_LEN-1:0] cnt;
    logic [WAYW-1:0]          victimWay;
    logic [TAG_ADDR_LEN-1:0]  victimTag;
    logic [31:0]              hitCount, missCount;

    logic [LINE_ADDR_LEN-1:0] wordOff;
    logic [SET_ADDR_LEN-1:0]  setIdx;
    logic [TAG_ADDR_LEN-1:0]  reqTag;
    logic                     req, hit, anyInv, lruUpd;
    logic [WAYW-1:0]          hitWay, invWay, oldWay, oldAge, victim, lruWay;

    assign wordOff = bus.addr[LINE_ADDR_LEN+1:2];
    assign setIdx  = bus.addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign reqTag  = bus.addr[LINE_ADDR_LEN+SET_ADDR_LEN+TAG_ADDR_LEN+1:LINE_ADDR_LEN+SET_ADDR_LEN+2];
    assign req     = bus.rd_req | bus.wr_req;

    always_comb begin
        hit    = 1'b0;
        hitWay = '0;
        anyInv = 1'b0;
        invWay = '0;
        oldWay = '0;
        oldAge = '0;
        for (int w = WAY_CNT - 1; w >= 0; w--)
            if (!validBits[w][setIdx]) begin
                anyInv = 1'b1;
                invWay = WAYW'(w);
            end
        for (int w = 0; w < WAY_CNT; w++) begin
            if (validBits[w][setIdx] && tagMem[w][setIdx] == reqTag) begin
                hit    = 1'b1;
                hitWay = WAYW'(w);
            end
            if (ages[w][setIdx] > oldAge) begin
                oldAge = ages[w][setIdx];
                oldWay = WAYW'(w);
            end
        end
    end

    assign victim = anyInv ? invWay : (REPLACE != 0 ? oldWay : fifoPtr[setIdx]);
    assign lruUpd = (state == IDLE && req && hit) || state == SWAP_IN_OK;
    assign lruWay = state == IDLE ? hitWay : victimWay;

    assign bus.rd_data    = hit ? dataMem[hitWay][setIdx][wordOff] : '0;
    assign bus.miss       = state != IDLE || (req && !hit);
    assign bus.mem_req    = state == SWAP_OUT || state == SWAP_IN;
    assign bus.mem_we     = state == SWAP_OUT;
    assign bus.mem_addr   = state == SWAP_OUT ? 32'({victimTag, setIdx, cnt, 2'b00}) :
                            state == SWAP_IN  ? 32'({reqTag, setIdx, cnt, 2'b00}) : '0;
    assign bus.mem_wdata  = state == SWAP_OUT ? dataMem[victimWay][setIdx][cnt] : '0;
    assign bus.hit_count  = hitCount;
    assign bus.miss_count = missCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            victimWay <= '0;
            victimTag <= '0;
            hitCount  <= '0;
            missCount <= '0;
            for (int s = 0; s < SETS; s++)
                fifoPtr[s] <= '0;
            for (int w = 0; w < WAY_CNT; w++)
                for (int s = 0; s < SETS; s++) begin
                    validBits[w][s] <= 1'b0;
                    dirtyBits[w][s] <= 1'b0;
                    ages[w][s]      <= '0;
                end
        end else begin
            case (state)
                IDLE:
                    if (req && !hit) begin
                        victimWay <= victim;
                        victimTag <= tagMem[victim][setIdx];
                        missCount <= missCount + 1;
                        state     <= validBits[victim][setIdx] && dirtyBits[victim][setIdx] ? SWAP_OUT : SWAP_IN;
                    end else if (req) begin
                        hitCount <= hitCount + 1;
                        if (bus.wr_req)
                            dirtyBits[hitWay][setIdx] <= 1'b1;
                    end
                SWAP_OUT:
                    if (bus.mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (&cnt)
                            state <= SWAP_IN;
                    end
                SWAP_IN:
                    if (bus.mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (&cnt)
                            state <= SWAP_IN_OK;
                    end
                SWAP_IN_OK: begin
                    tagMem[victimWay][setIdx]    <= reqTag;
                    validBits[victimWay][setIdx] <= 1'b1;
                    dirtyBits[victimWay][setIdx] <= 1'b0;
                    fifoPtr[setIdx]              <= WAY_CNT > 1 ? fifoPtr[setIdx] + 1'b1 : '0;
                    state                        <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // equal ages (left over from reset) count as younger so the ages settle into a permutation
            if (REPLACE != 0 && lruUpd)
                for (int w = 0; w < WAY_CNT; w++)
                    if (WAYW'(w) == lruWay)
                        ages[w][setIdx] <= '0;
                    else if (ages[w][setIdx] <= ages[lruWay][setIdx] && ages[w][setIdx] != WAYW'(WAY_CNT - 1))
                        ages[w][setIdx] <= ages[w][setIdx] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == SWAP_IN && bus.mem_ack)
            dataMem[victimWay][setIdx][cnt] <= bus.mem_rdata;
        else if (state == IDLE && bus.wr_req && hit)
            dataMem[hitWay][setIdx][wordOff] <= bus.wr_data;
    end
endmodule

// File: tb/tb_dcache_sa.sv
// tb_dcache_sa: directed checks of dcache_sa with an LRU and a FIFO instance.
module tb_dcache_sa;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic [31:0] addr = 0, wrData = 0;
    logic rdReq = 0, wrReq = 0, sel = 0, ackEn = 1;

    dcache_sa_if bl();
    dcache_sa_if bf();

    assign bl.addr      = addr;
    assign bl.wr_data   = wrData;
    assign bl.rd_req    = rdReq & ~sel;
    assign bl.wr_req    = wrReq & ~sel;
    assign bl.mem_rdata = bl.mem_addr;
    assign bl.mem_ack   = ackEn;
    assign bf.addr      = addr;
    assign bf.wr_data   = wrData;
    assign bf.rd_req    = rdReq & sel;
    assign bf.wr_req    = wrReq & sel;
    assign bf.mem_rdata = bf.mem_addr;
    assign bf.mem_ack   = ackEn;

    dcache_sa #(.REPLACE(1)) dutL (.clk(clk), .rst(rst), .bus(bl.slave));
    dcache_sa #(.REPLACE(0)) dutF (.clk(clk), .rst(rst), .bus(bf.slave));

    logic missS, memReqS, memWeS;
    logic [31:0] memAddrS, memWdataS, rdDataS, hitCntS, missCntS;
    assign missS     = sel ? bf.miss       : bl.miss;
    assign memReqS   = sel ? bf.mem_req    : bl.mem_req;
    assign memWeS    = sel ? bf.mem_we     : bl.mem_we;
    assign memAddrS  = sel ? bf.mem_addr   : bl.mem_addr;
    assign memWdataS = sel ? bf.mem_wdata  : bl.mem_wdata;
    assign rdDataS   = sel ? bf.rd_data    : bl.rd_data;
    assign hitCntS   = sel ? bf.hit_count  : bl.hit_count;
    assign missCntS  = sel ? bf.miss_count : bl.miss_count;

    int passed = 0, total = 0;
    logic [31:0] logAddr [64];
    logic [31:0] logData [64];
    logic        logWe   [64];
    int logN, missCycles, stallAt = -1, stallLeft = 0;
    logic [31:0] rdSeen, holdAddr;
    logic holdOk;

    // one request held until it completes; logs every acked memory word
    task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d);
        addr = a; wrReq = w; rdReq = !w; wrData = d;
        logN = 0; missCycles = 0; holdOk = 1; holdAddr = 0;
        @(negedge clk);
        while (missS && missCycles < 200) begin
            missCycles++;
            if (stallAt >= 0 && logN == stallAt && stallLeft > 0) begin
                if (ackEn) holdAddr = memAddrS;
                else if (memAddrS !== holdAddr || !memReqS) holdOk = 0;
                ackEn = 0;
                stallLeft--;
            end else ackEn = 1;
            if (memReqS && ackEn && logN < 64) begin
                logAddr[logN] = memAddrS; logData[logN] = memWdataS; logWe[logN] = memWeS;
                logN++;
            end
            @(negedge clk);
        end
        ackEn = 1;
        if (missCycles >= 200) begin
            total++;
            $display("FAIL access_timeout addr=%h: miss still high after %0d cycles", a, missCycles);
        end
        rdSeen = rdDataS;
        @(posedge clk); #1;
        rdReq = 0; wrReq = 0;
    endtask

    task automatic do_reset;
        rst = 1; rdReq = 0; wrReq = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset;
        sel = 0;
        do_reset();
        @(negedge clk);
        total++; if (bl.miss !== 1'b0) $display("FAIL reset_miss: got %b want 0", bl.miss); else passed++;
        total++; if (bl.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", bl.mem_req); else passed++;
        total++; if (bl.mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", bl.mem_addr); else passed++;
        total++; if (bl.rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h want 0", bl.rd_data); else passed++;
        total++; if (bl.hit_count !== 32'h0 || bl.miss_count !== 32'h0)
            $display("FAIL reset_counters: got %0d/%0d want 0/0", bl.hit_count, bl.miss_count); else passed++;
        total++; if (bf.mem_req !== 1'b0 || bf.miss !== 1'b0)
            $display("FAIL reset_fifo_idle: got req=%b miss=%b want 0/0", bf.mem_req, bf.miss); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_clean_miss;
        logic ok;
        int bad;
        access(32'h100, 0, 0);
        total++; if (missCycles != 10) $display("FAIL clean_miss_cycles: got %0d want 10", missCycles); else passed++;
        ok = (logN == 8); bad = -1;
        for (int i = 0; i < 8; i++)
            if (logWe[i] !== 1'b0 || logAddr[i] !== 32'h100 + 32'(4 * i)) begin ok = 0; if (bad < 0) bad = i; end
        total++; if (!ok) $display("FAIL clean_fill_seq: words=%0d first bad=%0d addr=%h want 8 reads 0x100..0x11C", logN, bad, logAddr[bad < 0 ? 0 : bad]); else passed++;
        total++; if (rdSeen !== 32'h100) $display("FAIL clean_rd_data: got %h want 00000100", rdSeen); else passed++;
        total++; if (hitCntS !== 1 || missCntS !== 1) $display("FAIL clean_counters: got %0d/%0d want 1/1", hitCntS, missCntS); else passed++;
    endtask

    task automatic test_write_hit;
        access(32'h104, 1, 32'hDEADBEEF);
        total++; if (missCycles != 0) $display("FAIL write_hit_miss: got %0d want 0", missCycles); else passed++;
        access(32'h104, 0, 0);
        total++; if (missCycles != 0 || rdSeen !== 32'hDEADBEEF)
            $display("FAIL read_after_write: got %h miss=%0d want deadbeef miss=0", rdSeen, missCycles); else passed++;
        total++; if (hitCntS !== 3 || missCntS !== 1) $display("FAIL write_counters: got %0d/%0d want 3/1", hitCntS, missCntS); else passed++;
    endtask

    task automatic test_lru_evict;
        logic ok;
        int bad;
        access(32'h100, 0, 0);
        total++; if (missCycles != 0) $display("FAIL touch_100_hit: got %0d want 0", missCycles); else passed++;
        access(32'h180, 0, 0);
        total++; if (missCycles != 10 || rdSeen !== 32'h180) $display("FAIL fill_180: got %0d cycles rd=%h want 10 00000180", missCycles, rdSeen); else passed++;
        access(32'h200, 0, 0);
        total++; if (missCycles != 18) $display("FAIL dirty_miss_cycles: got %0d want 18", missCycles); else passed++;
        ok = (logN == 16); bad = -1;
        for (int i = 0; i < 8; i++)
            if (logWe[i] !== 1'b1 || logAddr[i] !== 32'h100 + 32'(4 * i) ||
                logData[i] !== (i == 1 ? 32'hDEADBEEF : 32'h100 + 32'(4 * i))) begin ok = 0; if (bad < 0) bad = i; end
        for (int i = 8; i < 16; i++)
            if (logWe[i] !== 1'b0 || logAddr[i] !== 32'h200 + 32'(4 * (i - 8))) begin ok = 0; if (bad < 0) bad = i; end
        total++; if (!ok) $display("FAIL writeback_seq: words=%0d first bad=%0d addr=%h data=%h", logN, bad, logAddr[bad < 0 ? 0 : bad], logData[bad < 0 ? 0 : bad]); else passed++;
        total++; if (rdSeen !== 32'h200) $display("FAIL evict_rd_data: got %h want 00000200", rdSeen); else passed++;
        access(32'h180, 0, 0);
        total++; if (missCycles != 0) $display("FAIL lru_kept_180: got %0d want 0", missCycles); else passed++;
        total++; if (hitCntS !== 7 || missCntS !== 3) $display("FAIL evict_counters: got %0d/%0d want 7/3", hitCntS, missCntS); else passed++;
    endtask

    task automatic test_stall;
        stallAt = 3; stallLeft = 5;
        access(32'h300, 0, 0);
        stallAt = -1;
        total++; if (missCycles != 15) $display("FAIL stall_cycles: got %0d want 15", missCycles); else passed++;
        total++; if (holdAddr !== 32'h30C || !holdOk) $display("FAIL stall_hold: got %h held=%b want 0000030c held=1", holdAddr, holdOk); else passed++;
        total++; if (rdSeen !== 32'h300) $display("FAIL stall_rd_data: got %h want 00000300", rdSeen); else passed++;
    endtask

    task automatic test_reset_mid;
        addr = 32'h400; rdReq = 1; wrReq = 0;
        repeat (3) @(negedge clk);
        total++; if (memReqS !== 1'b1 || memWeS !== 1'b0) $display("FAIL mid_fill_active: got req=%b we=%b want 1/0", memReqS, memWeS); else passed++;
        rst = 1; rdReq = 0;
        @(negedge clk);
        total++; if (memReqS !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", memReqS); else passed++;
        total++; if (hitCntS !== 0 || missCntS !== 0) $display("FAIL rst_counters: got %0d/%0d want 0/0", hitCntS, missCntS); else passed++;
        @(posedge clk); #1 rst = 0;
        access(32'h400, 0, 0);
        total++; if (missCycles != 10 || rdSeen !== 32'h400) $display("FAIL reread_400: got %0d cycles rd=%h want 10 00000400", missCycles, rdSeen); else passed++;
        access(32'h100, 0, 0);
        total++; if (missCycles != 10) $display("FAIL reread_100_invalid: got %0d want 10", missCycles); else passed++;
    endtask

    task automatic run_policy_seq(input logic s);
        sel = s;
        do_reset();
        access(32'h100, 0, 0);
        access(32'h104, 1, 32'hDEADBEEF);
        access(32'h180, 0, 0);
        access(32'h100, 0, 0);
        access(32'h200, 0, 0);
    endtask

    task automatic test_lru_policy;
        run_policy_seq(0);
        total++; if (missCycles != 10 || logN != 8) $display("FAIL lru_victim_180: got %0d cycles %0d words want 10/8", missCycles, logN); else passed++;
        access(32'h104, 0, 0);
        total++; if (missCycles != 0 || rdSeen !== 32'hDEADBEEF) $display("FAIL lru_kept_100: got %0d rd=%h want 0 deadbeef", missCycles, rdSeen); else passed++;
    endtask

    task automatic test_fifo;
        run_policy_seq(1);
        total++; if (missCycles != 18) $display("FAIL fifo_dirty_cycles: got %0d want 18", missCycles); else passed++;
        total++; if (logN != 16 || logWe[1] !== 1'b1 || logAddr[1] !== 32'h104 || logData[1] !== 32'hDEADBEEF)
            $display("FAIL fifo_writeback: words=%0d we=%b addr=%h data=%h want 16 1 00000104 deadbeef", logN, logWe[1], logAddr[1], logData[1]); else passed++;
        access(32'h180, 0, 0);
        total++; if (missCycles != 0 || rdSeen !== 32'h180) $display("FAIL fifo_kept_180: got %0d rd=%h want 0 00000180", missCycles, rdSeen); else passed++;
        total++; if (hitCntS !== 6 || missCntS !== 3) $display("FAIL fifo_counters: got %0d/%0d want 6/3", hitCntS, missCntS); else passed++;
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_lru_evict();
        test_stall();
        test_reset_mid();
        test_lru_policy();
        test_fifo();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
